pe_group_instruction: RTL
=========================

PE_GROUP_INSTRUCTION -- requirements
Module: pe_group_instruction

Interface
REQ-001 Parameter NUM_PE, default 4, number of processing elements (PEs), range 1..8.
REQ-002 Parameter DATA_W, default 16, signed weight/input width, range 4..16.
REQ-003 Parameter ACC_W, default 32, signed accumulator width, range 2*DATA_W..32.
REQ-004 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, asynchronous, active-low reset.
REQ-006 Port clk_en, input, 1, global enable; when low, all state and outputs hold.
REQ-007 Port start, input, 1, one-cycle command strobe.
REQ-008 Port n, input, 3, opcode.
REQ-009 Port dataa, input, 32, operand (weight, input or bias value).
REQ-010 Port datab, input, 32, PE index.
REQ-011 Port result, output, 32, registered command result.
REQ-012 Port done, output, 1, one-cycle completion pulse.

Function
REQ-013 A command SHALL be accepted on a rising edge where start=1, clk_en=1 and the block is idle; n, dataa and datab are captured on that edge.
REQ-014 start while busy SHALL be ignored, with no effect on state.
REQ-015 Opcodes SHALL be:
- 0 CLEAR: all accumulators and overflow flags set to 0.
- 1 LOAD_W: weight[datab] = dataa[DATA_W-1:0].
- 2 SET_BIAS: acc[datab] = dataa[ACC_W-1:0].
- 3 RUN: x = dataa[DATA_W-1:0]; every PE performs acc[i] += weight[i]*x.
- 4 READ: result = acc[datab], sign-extended to 32 bits.
- 5 STATUS: result[NUM_PE-1:0] = sticky overflow flags; upper bits 0.
- 6, 7 reserved: no state change; result = 0.
REQ-016 Opcodes other than RUN SHALL assert done for exactly one cycle immediately after the accepting edge, with result valid in that same cycle.
REQ-017 RUN SHALL use one shared multiplier and update PE i on accepting edge + 1 + i, so updates proceed in index order.
REQ-018 RUN SHALL assert done for one cycle after edge + NUM_PE, with result = 0.
REQ-019 FSM states SHALL be:
- IDLE -> RESP on a non-RUN command.
- IDLE -> MAC on RUN.
- MAC iterates pe_cnt from 0 to NUM_PE-1, then -> RESP.
- RESP -> IDLE.
REQ-020 done SHALL be high only in RESP; in all other states done=0 and result holds its last value.
REQ-021 The product SHALL be signed 2*DATA_W bits, sign-extended to ACC_W.
REQ-022 On signed overflow, the sum SHALL saturate to +2^(ACC_W-1)-1 or -2^(ACC_W-1) and set that PE's sticky overflow flag.
REQ-023 A datab value >= NUM_PE SHALL make LOAD_W and SET_BIAS no-ops and make READ return 0; done still pulses normally.
REQ-024 With clk_en=0, the FSM, counters, accumulators, result and done SHALL hold; a pending done pulse is extended until clk_en returns.
REQ-025 Weights SHALL persist across CLEAR and RUN; only reset and LOAD_W change them.

Reset
REQ-026 reset=0 SHALL immediately force the FSM to IDLE; weights, accumulators, flags, pe_cnt, result and done all go to 0.
REQ-027 Reset during MAC SHALL abort the operation with no done pulse; the first command after reset release is accepted normally.

Verification
REQ-028 NUM_PE=4, DATA_W=16. Stimulus: LOAD_W 1,2,3,4 to PEs 0..3, then RUN x=5, then READ 0..3. Required: 5, 10, 15, 20; RUN done exactly 4 edges after the accepting edge.
REQ-029 Stimulus: LOAD_W PE1 = 0xFFFD (-3), CLEAR, RUN x=4, READ 1. Required: 0xFFFFFFF4.
REQ-030 Stimulus: SET_BIAS PE0 = 0x7FFFFFF0, LOAD_W PE0 = 0x7FFF, RUN x=0x7FFF, READ 0, then STATUS. Required: READ = 0x7FFFFFFF; STATUS bit0 = 1; STATUS = 0 after CLEAR.
REQ-031 Stimulus: RUN with clk_en dropped for 3 cycles mid-MAC. Required: done delayed by exactly 3 cycles and accumulators correct; start pulses during MAC ignored.
REQ-032 Stimulus: reset asserted at the second MAC cycle. Required: all outputs 0, no done pulse; READ of every PE returns 0.
REQ-033 Stimulus: LOAD_W with datab=7 on NUM_PE=4, then READ datab=9. Required: done pulses; no PE weight changes; READ result = 0.

Source files
------------

// File: rtl/pe_group_instruction.sv
// Group of NUM_PE signed multiply-accumulate elements driven by a single-strobe
// command interface; RUN walks the PEs in index order through one shared multiplier.
module pe_group_instruction #(
    parameter int NUM_PE = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [2:0]  n,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, MAC, RESP} state_t;
    typedef enum logic [2:0] {
        OP_CLEAR, OP_LOAD_W, OP_SET_BIAS, OP_RUN, OP_READ, OP_STATUS, OP_RSVD6, OP_RSVD7
    } op_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t state, state_next;
    op_t    op;

    logic signed [DATA_W-1:0]   weight [NUM_PE];
    logic signed [ACC_W-1:0]    acc    [NUM_PE];
    logic        [NUM_PE-1:0]   ovf;
    logic signed [DATA_W-1:0]   x_reg;
    logic        [2:0]          pe_cnt;

    logic                       accept;
    logic                       last_pe;
    logic signed [DATA_W-1:0]   weight_sel;
    logic signed [ACC_W-1:0]    acc_sel;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic        [ACC_W:0]      sum;
    logic                       sum_ovf;
    logic signed [ACC_W-1:0]    sum_sat;

    assign op      = op_t'(n);
    assign accept  = clk_en && start && (state == IDLE);
    assign last_pe = (pe_cnt == 3'(NUM_PE - 1));
    assign done    = (state == RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else if (clk_en) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (op == OP_RUN) ? MAC : RESP;
            MAC:     if (last_pe) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shared MAC: select the PE addressed by pe_cnt, add with one guard bit, saturate.
    always_comb begin
        weight_sel = '0;
        acc_sel    = '0;
        for (int unsigned i = 0; i < NUM_PE; i++) begin
            if (pe_cnt == 3'(i)) begin
                weight_sel = weight[i];
                acc_sel    = acc[i];
            end
        end
        prod     = (2*DATA_W)'(weight_sel) * (2*DATA_W)'(x_reg);
        prod_ext = ACC_W'(prod);
        sum      = {acc_sel[ACC_W-1], acc_sel} + {prod_ext[ACC_W-1], prod_ext};
        sum_ovf  = (sum[ACC_W] != sum[ACC_W-1]);
        sum_sat  = sum_ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_PE; i++) begin
                weight[i] <= '0;
                acc[i]    <= '0;
            end
            ovf    <= '0;
            x_reg  <= '0;
            pe_cnt <= '0;
            result <= '0;
        end else if (clk_en) begin
            if (accept) begin
                case (op)
                    OP_CLEAR: begin
                        for (int unsigned i = 0; i < NUM_PE; i++) acc[i] <= '0;
                        ovf    <= '0;
                        result <= '0;
                    end
                    OP_LOAD_W: begin
                        for (int unsigned i = 0; i < NUM_PE; i++)
                            if (datab == 32'(i)) weight[i] <= dataa[DATA_W-1:0];
                        result <= '0;
                    end
                    OP_SET_BIAS: begin
                        for (int unsigned i = 0; i < NUM_PE; i++)
                            if (datab == 32'(i)) acc[i] <= dataa[ACC_W-1:0];
                        result <= '0;
                    end
                    OP_RUN: begin
                        x_reg  <= dataa[DATA_W-1:0];
                        pe_cnt <= '0;
                    end
                    OP_READ: begin
                        result <= '0;
                        for (int unsigned i = 0; i < NUM_PE; i++)
                            if (datab == 32'(i)) result <= 32'(acc[i]);
                    end
                    OP_STATUS: result <= 32'(ovf);
                    default:   result <= '0;
                endcase
            end
            if (state == MAC) begin
                for (int unsigned i = 0; i < NUM_PE; i++) begin
                    if (pe_cnt == 3'(i)) begin
                        acc[i] <= sum_sat;
                        if (sum_ovf) ovf[i] <= 1'b1;
                    end
                end
                if (last_pe) begin
                    pe_cnt <= '0;
                    result <= '0;
                end else begin
                    pe_cnt <= pe_cnt + 3'd1;
                end
            end
        end
    end

endmodule
